// File: rtl/div_unit_pkg.sv
// ----------------------------------------------------------------------------
// div_unit_pkg -- RV32M divide encodings and FSM state codes
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package div_unit_pkg;

    localparam logic [2:0] DIV_F3    = 3'b100;
    localparam logic [2:0] DIVU_F3   = 3'b101;
    localparam logic [2:0] REM_F3    = 3'b110;
    localparam logic [2:0] REMU_F3   = 3'b111;
    localparam logic [6:0] MULDIV_F7 = 7'b0000001;

    localparam logic [1:0] DIV_IDLE  = 2'd0;
    localparam logic [1:0] DIV_RUN   = 2'd1;
    localparam logic [1:0] DIV_DONE  = 2'd2;

    // func3[0] clear selects the signed variants, func3[1] set selects remainder
    function automatic logic f3_is_signed(input logic [2:0] f3);
        return ~f3[0];
    endfunction

    function automatic logic f3_is_rem(input logic [2:0] f3);
        return f3[1];
    endfunction

endpackage

`default_nettype wire

// File: rtl/div_unit_step.sv
// ----------------------------------------------------------------------------
// div_step -- one restoring shift/trial-subtract divide step
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_i,
    input  logic [XLEN-1:0] quo_i,
    input  logic [XLEN-1:0] div_i,
    output logic [XLEN-1:0] rem_o,
    output logic [XLEN-1:0] quo_o
);

    logic [XLEN:0] shift_w;
    logic [XLEN:0] diff_w;

    // One extra bit: the shifted remainder can reach 2*divisor-1
    assign shift_w = {rem_i, quo_i[XLEN-1]};
    assign diff_w  = shift_w - {1'b0, div_i};

    assign rem_o = diff_w[XLEN] ? shift_w[XLEN-1:0] : diff_w[XLEN-1:0];
    assign quo_o = {quo_i[XLEN-2:0], ~diff_w[XLEN]};

endmodule

`default_nettype wire

// File: rtl/div_unit.sv
// ----------------------------------------------------------------------------
// div_unit -- iterative RV32M DIV/DIVU/REM/REMU unit with pipeline stall
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module div_unit
    import div_unit_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dvs_q, dvs_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            signed_q, signed_d;
    logic            is_rem_q, is_rem_d;
    logic            sign_a_q, sign_a_d;
    logic            sign_b_q, sign_b_d;

    logic            accept_w;
    logic            req_signed_w;
    logic            sa_w, sb_w;
    logic [XLEN-1:0] mag_a_w, mag_b_w;
    logic            div_zero_w, ovf_w;
    logic [XLEN-1:0] special_w;
    logic [XLEN-1:0] step_rem_w, step_quo_w;
    logic [XLEN-1:0] quo_fix_w, rem_fix_w;

    assign accept_w     = (state_q == DIV_IDLE) & start & func3[2] & ~flush;
    assign req_signed_w = f3_is_signed(func3);
    assign sa_w         = req_signed_w & op_a[XLEN-1];
    assign sb_w         = req_signed_w & op_b[XLEN-1];
    assign mag_a_w      = sa_w ? (-op_a) : op_a;
    assign mag_b_w      = sb_w ? (-op_b) : op_b;
    assign div_zero_w   = (op_b == '0);
    assign ovf_w        = req_signed_w & (op_a == XLEN_MIN) & (op_b == '1);

    always_comb begin
        special_w = '0;
        if (div_zero_w) begin
            special_w = f3_is_rem(func3) ? op_a : '1;
        end else begin
            special_w = f3_is_rem(func3) ? '0 : XLEN_MIN;
        end
    end

    div_step #(
        .XLEN (XLEN)
    ) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem_w),
        .quo_o (step_quo_w)
    );

    // Sign fix-up is applied to the outputs of the final step
    assign quo_fix_w = (signed_q & (sign_a_q ^ sign_b_q)) ? (-step_quo_w) : step_quo_w;
    assign rem_fix_w = (signed_q & sign_a_q) ? (-step_rem_w) : step_rem_w;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;
        signed_d = signed_q;
        is_rem_d = is_rem_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        case (state_q)
            DIV_IDLE: begin
                if (accept_w) begin
                    signed_d = req_signed_w;
                    is_rem_d = f3_is_rem(func3);
                    sign_a_d = sa_w;
                    sign_b_d = sb_w;
                    if (div_zero_w || ovf_w) begin
                        result_d = special_w;
                        state_d  = DIV_DONE;
                    end else begin
                        rem_d   = '0;
                        quo_d   = mag_a_w;
                        dvs_d   = mag_b_w;
                        cnt_d   = '0;
                        state_d = DIV_RUN;
                    end
                end
            end
            DIV_RUN: begin
                if (flush) begin
                    state_d = DIV_IDLE;
                end else begin
                    rem_d = step_rem_w;
                    quo_d = step_quo_w;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        result_d = is_rem_q ? rem_fix_w : quo_fix_w;
                        state_d  = DIV_DONE;
                    end
                end
            end
            DIV_DONE: state_d = DIV_IDLE;
            default:  state_d = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DIV_IDLE;
            cnt_q    <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dvs_q    <= '0;
            result_q <= '0;
            signed_q <= 1'b0;
            is_rem_q <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
            signed_q <= signed_d;
            is_rem_q <= is_rem_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
        end
    end

    assign stall  = accept_w | (state_q == DIV_RUN);
    assign busy   = (state_q == DIV_RUN);
    assign done   = (state_q == DIV_DONE) & ~flush;
    assign result = result_q;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ----------------------------------------------------------------------------
// tb_div_unit -- scoreboard bench for div_unit
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  func3 = 3'b000;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        flush = 1'b0;
    logic        stall, busy, done;
    logic [31:0] result;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q[$];

    div_unit #(.XLEN(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .func3(func3),
        .op_a(op_a), .op_b(op_b), .flush(flush),
        .stall(stall), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0) return f3[1] ? a : 32'hFFFF_FFFF;
        if (!f3[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'd0 : 32'h8000_0000;
            return f3[1] ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        end
        return f3[1] ? (a % b) : (a / b);
    endfunction

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit push, output logic st);
        func3 = f3; op_a = a; op_b = b; start = 1'b1;
        if (push) exp_q.push_back(ref_res(f3, a, b));
        #1 st = stall;
    endtask

    // Counts cycles from the accepting edge to done; stall/busy must hold until then
    task automatic wait_done(output int lat, output bit hold_err);
        lat = -1; hold_err = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin start = 1'b0; op_a = $urandom; op_b = $urandom; end
            if (done) begin
                lat = n;
                if (stall) hold_err = 1'b1;
                break;
            end
            if (!stall || !busy) hold_err = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        checks++; if ({stall, busy, done} !== 3'b000) begin errors++; $display("FAIL reset_ctrl got=%b exp=000", {stall, busy, done}); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result got=%h exp=00000000", result); end
    endtask

    task automatic test_ops;
        logic [2:0]  f3 [12];
        logic [31:0] a  [12];
        logic [31:0] b  [12];
        int          el [12];
        logic st, res_ok; int lat; bit herr; logic [31:0] exp;
        f3 = '{3'b100, 3'b110, 3'b100, 3'b110, 3'b101, 3'b100, 3'b111, 3'b100, 3'b110, 3'b101, 3'b100, 3'b111};
        a  = '{32'd100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'd5, 32'd5,
               32'h8000_0000, 32'h8000_0000, 32'hDEAD_BEEF, 32'h8000_0000, 32'hFFFF_FFFE};
        b  = '{32'd7, 32'd7, 32'd2, 32'd2, 32'd1, 32'd0, 32'd0,
               32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1234, 32'd3, 32'h8000_0001};
        el = '{33, 33, 33, 33, 33, 1, 1, 1, 1, 33, 33, 33};
        for (int i = 0; i < 16; i++) begin
            if (i < 12) issue(f3[i], a[i], b[i], 1'b1, st);
            else issue({1'b1, 2'($urandom)}, $urandom, $urandom_range(1, 300) * ((i % 2) ? 32'd1 : 32'hFFFF_FFFF), 1'b1, st);
            checks++; if (st !== 1'b1) begin errors++; $display("FAIL op%0d_stall_at_start got=%b exp=1", i, st); end
            wait_done(lat, herr);
            checks++; if (lat !== ((i < 12) ? el[i] : 33)) begin errors++; $display("FAIL op%0d_latency got=%0d exp=%0d", i, lat, (i < 12) ? el[i] : 33); end
            checks++; if (herr) begin errors++; $display("FAIL op%0d_stall_hold got=1 exp=0", i); end
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            res_ok = (result === exp);
            checks++; if (!res_ok) begin errors++; $display("FAIL op%0d_result got=%h exp=%h", i, result, exp); end
            @(posedge clk); #1;
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL op%0d_done_pulse got=%b exp=0", i, done); end
        end
    endtask

    task automatic test_ignore;
        start = 1'b1; func3 = 3'b000; op_a = 32'd10; op_b = 32'd2;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ignore_stall got=%b exp=0", stall); end
        @(posedge clk); #1;
        start = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL ignore_state got=%b exp=00", {busy, done}); end
    endtask

    task automatic test_flush;
        logic st; int lat; bit herr; bit seen; logic [31:0] exp;
        issue(3'b101, 32'd1000, 32'd3, 1'b0, st);
        for (int n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checks++; if ({stall, busy, done} !== 3'b000) begin errors++; $display("FAIL flush_run got=%b exp=000", {stall, busy, done}); end
        seen = 1'b0;
        for (int n = 0; n < 40; n++) begin @(posedge clk); #1; if (done) seen = 1'b1; end
        checks++; if (seen) begin errors++; $display("FAIL flush_no_done got=1 exp=0"); end
        start = 1'b1; flush = 1'b1; func3 = 3'b100; op_a = 32'd9; op_b = 32'd3;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_start_stall got=%b exp=0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL flush_start_state got=%b exp=00", {busy, done}); end
        issue(3'b101, 32'd9, 32'd3, 1'b1, st);
        wait_done(lat, herr);
        checks++; if (lat !== 33) begin errors++; $display("FAIL after_flush_latency got=%0d exp=33", lat); end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
        checks++; if (result !== exp) begin errors++; $display("FAIL after_flush_result got=%h exp=%h", result, exp); end
    endtask

    task automatic test_back_to_back;
        int first, second; logic [31:0] exp;
        first = -1; second = -1;
        @(posedge clk); #1;
        start = 1'b1; func3 = 3'b100; op_a = 32'd20; op_b = 32'd4;
        exp_q.push_back(ref_res(3'b100, 32'd20, 32'd4));
        exp_q.push_back(ref_res(3'b111, 32'd20, 32'd6));
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (n == 1) begin func3 = 3'b111; op_a = 32'd20; op_b = 32'd6; end
            if (n == 35) start = 1'b0;
            if (n == 34) begin
                checks++; if (stall !== 1'b1) begin errors++; $display("FAIL b2b_accept_stall got=%b exp=1", stall); end
            end
            if (done) begin
                exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
                checks++; if (result !== exp) begin errors++; $display("FAIL b2b_result@%0d got=%h exp=%h", n, result, exp); end
                if (first < 0) begin
                    first = n;
                    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_done_stall got=%b exp=0", stall); end
                end else begin
                    second = n;
                    break;
                end
            end
        end
        checks++; if (first !== 33) begin errors++; $display("FAIL b2b_first_done got=%0d exp=33", first); end
        checks++; if (second !== 67) begin errors++; $display("FAIL b2b_second_done got=%0d exp=67", second); end
    endtask

    task automatic test_rst_mid_run;
        logic st;
        @(posedge clk); #1;
        issue(3'b100, 32'd100, 32'd7, 1'b0, st);
        for (int n = 1; n <= 5; n++) begin
            @(posedge clk); #1;
            if (n == 1) start = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if ({stall, busy, done} !== 3'b000) begin errors++; $display("FAIL rst_mid_ctrl got=%b exp=000", {stall, busy, done}); end
        checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_mid_result got=%h exp=00000000", result); end
    endtask

    initial begin
        test_reset();
        test_ops();
        test_ignore();
        test_flush();
        test_back_to_back();
        test_rst_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative RV32M divider for DIV, DIVU, REM and REMU, in the execute stage beside the ALU.
- Consumes the same func3 and forwarded operands that drive ALU control.
- Holds the pipeline through a stall output while iterating.
- Produces a 32-bit result that the EX result mux selects when done is high.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must hold XLEN.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  EX holds a divide-class instruction (opcode OP, func7=0000001, func3[2]=1).
- func3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU.
- op_a  input  XLEN  dividend (rs1 after forwarding).
- op_b  input  XLEN  divisor (rs2 after forwarding).
- flush  input  1  EX flush (branch mispredict / trap).
- stall  output  1  freeze IF/ID/EX while divide is pending.
- busy  output  1  state is RUN.
- done  output  1  one-cycle result-valid pulse.
- result  output  XLEN  quotient or remainder; valid only while done=1.

Behaviour:
- States: IDLE, RUN, DONE. Reset forces IDLE; rst dominates every other input.
- Reset values: done=0, busy=0, result=0, counter=0, internal regs=0.
- IDLE with start=1 and func3[2]=1 latches func3 and operand signs.
  - Signed ops: magnitudes |op_a| and |op_b|. Unsigned ops: raw operands.
  - Special cases go straight to DONE:
    - Divide by zero (op_b=0): quotient 0xFFFFFFFF, remainder op_a.
    - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): quotient 0x80000000, remainder 0.
  - Otherwise go to RUN with counter=0.
- IDLE with start=1 and func3[2]=0: ignored; no stall, no state change.
- RUN: one restoring step per cycle.
  - Shift {rem,quo} left by 1, trial-subtract the divisor magnitude, keep the result if it is non-negative and set the quo LSB.
  - Counter increments each cycle; after the XLEN-th step, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
  - start is ignored in DONE; a following divide is accepted in the next IDLE cycle.
- Sign fix-up is applied when result is registered on entry to DONE:
  - Quotient negated if sign_a^sign_b (signed ops only).
  - Remainder takes the sign of op_a (signed ops only).
- Latency: start sampled at cycle T.
  - Normal case: done at T+XLEN+1 (T+33).
  - Special cases: done at T+1.
- stall = (IDLE & start & func3[2]) | RUN. stall is combinational and deasserted in DONE so the instruction retires that cycle.
- Operands latched at start; later changes on op_a/op_b are ignored.
- flush in RUN or DONE: IDLE next cycle, done stays 0, result unchanged.
- flush in IDLE with start=1: start not accepted.
- flush together with start: flush wins.
- Magnitude of 0x80000000 is 0x80000000 as an unsigned XLEN value; no overflow in the iteration path.

Decomposition:
- defines.vh holds:
  - func3 codes DIV_F3=3'b100, DIVU_F3=3'b101, REM_F3=3'b110, REMU_F3=3'b111.
  - MULDIV_F7=7'b0000001.
  - State encodings DIV_IDLE, DIV_RUN, DIV_DONE.
- One combinational sub-module, div_step: inputs partial remainder, quotient and divisor; outputs the next remainder and quotient. Instantiated once.

Test Plan:
- DIV 100/7 at T -> stall high T..T+32, done at T+33, result=14. REM same operands -> result=2.
- DIV -7/2 -> result 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). DIVU 0xFFFFFFFF/1 -> 0xFFFFFFFF, done at T+33.
- DIV 5/0 -> done at T+1, 0xFFFFFFFF. REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> done at T+1, 0x80000000. REM same operands -> 0.
- flush at T+10 of a DIVU 1000/3 -> no done pulse, stall low at T+11, state IDLE. Then a new DIVU 9/3 completes with 3.
- Back-to-back DIV 20/4 then REMU 20/6 with start held high -> first done at T+33, second accepted at T+34, done at T+67 with result 2. rst asserted mid-RUN -> all outputs 0 next cycle.
